// File: rtl/hex_uart_tx.sv
// Serial debug tap: whenever the monitored 16-bit bus changes, send it as four
// uppercase ASCII hex digits plus CR LF over an 8N1 UART line (LSB first).
module hex_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            frames_sent
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_r,     state_s;
    logic [BAUD_W-1:0]     baud_r,      baud_s;
    logic [2:0]            bit_r,       bit_s;
    logic [2:0]            byte_r,      byte_s;
    logic [DATA_WIDTH-1:0] frame_val_r, frame_val_s;
    logic [DATA_WIDTH-1:0] last_sent_r, last_sent_s;
    logic [7:0]            frames_s;
    logic [7:0]            char_s;
    logic                  tx_s;
    logic                  busy_s;
    logic                  baud_end_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_char(input logic [15:0] val, input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = hex_ascii(val[15:12]);
            3'd1:    c = hex_ascii(val[11:8]);
            3'd2:    c = hex_ascii(val[7:4]);
            3'd3:    c = hex_ascii(val[3:0]);
            3'd4:    c = 8'h0D;
            3'd5:    c = 8'h0A;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // Next-state, counters and the next value of every registered output.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_s       = bit_r;
        byte_s      = byte_r;
        frame_val_s = frame_val_r;
        last_sent_s = last_sent_r;
        frames_s    = frames_sent;
        char_s      = 8'h00;
        tx_s        = 1'b1;
        busy_s      = 1'b0;
        baud_end_s  = (baud_r == BAUD_LAST);

        case (state_r)
            ST_IDLE: begin
                baud_s = {BAUD_W{1'b0}};
                bit_s  = 3'd0;
                byte_s = 3'd0;
                if (data_in != last_sent_r) begin
                    frame_val_s = data_in;
                    last_sent_s = data_in;
                    state_s     = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (byte_r == 3'd5) begin
                        byte_s   = 3'd0;
                        frames_s = frames_sent + 8'd1;
                        state_s  = ST_IDLE;
                    end else begin
                        byte_s  = byte_r + 3'd1;
                        state_s = ST_START;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so tx/busy can be registered
        // without adding latency beyond the latching edge.
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA: begin
                char_s = frame_char(frame_val_s, byte_s);
                tx_s   = char_s[bit_s];
            end
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            baud_r      <= {BAUD_W{1'b0}};
            bit_r       <= 3'd0;
            byte_r      <= 3'd0;
            frame_val_r <= {DATA_WIDTH{1'b0}};
            last_sent_r <= {DATA_WIDTH{1'b0}};
            frames_sent <= 8'd0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_r      <= baud_s;
            bit_r       <= bit_s;
            byte_r      <= byte_s;
            frame_val_r <= frame_val_s;
            last_sent_r <= last_sent_s;
            frames_sent <= frames_s;
            tx          <= tx_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_hex_uart_tx.sv
// Directed bench for hex_uart_tx: a UART receiver model decodes tx and checks
// each byte against a queue of expected characters pushed when stimulus is driven.
module tb_hex_uart_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        tx;
    logic        busy;
    logic [7:0]  frames_sent;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] scb[$];
    string       hex_digits = "0123456789ABCDEF";

    hex_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] v);
        scb.push_back({24'h0, hex_digits.getc(int'(v[15:12]))});
        scb.push_back({24'h0, hex_digits.getc(int'(v[11:8]))});
        scb.push_back({24'h0, hex_digits.getc(int'(v[7:4]))});
        scb.push_back({24'h0, hex_digits.getc(int'(v[3:0]))});
        scb.push_back(32'h0000_000D);
        scb.push_back(32'h0000_000A);
    endtask

    task automatic wait_busy(input logic lvl);
        int n;
        n = 0;
        while (busy !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", {31'h0, busy}, {31'h0, lvl});
    endtask

    task automatic send(input logic [15:0] v);
        data_in = v;
        push_frame(v);
        wait_busy(1'b1);
        wait_busy(1'b0);
    endtask

    // UART receiver: samples mid-bit, pops the scoreboard at each stop bit.
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic [31:0] exp_byte;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) begin
                chk("start_bit", {31'h0, tx}, 32'h0);
            end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 2) % 4 == 0) begin
                mon_byte = {tx, mon_byte[7:1]};
            end else if (mon_cnt == 38) begin
                chk("stop_bit", {31'h0, tx}, 32'h1);
                exp_byte = (scb.size() > 0) ? scb.pop_front() : 32'hFFFF_FFFF;
                chk("rx_byte", {24'h0, mon_byte}, exp_byte);
                mon_active = 1'b0;
            end
        end
    end

    // Busy-run length and idle-gap monitor.
    logic prev_busy = 1'b0;
    logic gap_en    = 1'b0;
    int   blen      = 0;
    int   idle_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            blen      = 0;
            idle_cnt  = 0;
        end else begin
            if (busy) begin
                if (!prev_busy) begin
                    if (gap_en) chk("idle_gap", idle_cnt, 32'd1);
                    blen = 0;
                end
                blen++;
            end else begin
                if (prev_busy) begin
                    chk("busy_len", blen, 32'd240);
                    idle_cnt = 0;
                end
                idle_cnt++;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int busy_seen;
        logic [15:0] v;

        // Reset defaults
        rst     = 1'b1;
        data_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_frames", {24'h0, frames_sent}, 32'h0);
        rst = 1'b0;
        lows = 0;
        busy_seen = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busy_seen++;
        end
        chk("idle_no_start", lows, 32'd0);
        chk("idle_no_busy", busy_seen, 32'd0);

        // Single frame with start-bit latency
        data_in = 16'h1A2F;
        push_frame(16'h1A2F);
        chk("pre_latch_tx", {31'h0, tx}, 32'h1);
        @(negedge clk);
        chk("latency_tx", {31'h0, tx}, 32'h0);
        chk("latency_busy", {31'h0, busy}, 32'h1);
        wait_busy(1'b0);
        chk("frames_1", {24'h0, frames_sent}, 32'd1);

        // Hex digit boundaries
        send(16'h09AF);
        send(16'hFFFF);
        chk("frames_3", {24'h0, frames_sent}, 32'd3);

        // Coalescing: 0x0002 is dropped, 0x0003 follows
        data_in = 16'h0001;
        push_frame(16'h0001);
        wait_busy(1'b1);
        repeat (30) @(negedge clk);
        data_in = 16'h0002;
        repeat (30) @(negedge clk);
        data_in = 16'h0003;
        push_frame(16'h0003);
        wait_busy(1'b0);
        wait_busy(1'b1);
        wait_busy(1'b0);
        chk("frames_5", {24'h0, frames_sent}, 32'd5);

        // Value that returns to last_sent while busy is not resent
        data_in = 16'h0005;
        push_frame(16'h0005);
        wait_busy(1'b1);
        repeat (20) @(negedge clk);
        data_in = 16'h0007;
        repeat (20) @(negedge clk);
        data_in = 16'h0005;
        wait_busy(1'b0);
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        chk("no_resend", busy_seen, 32'd0);
        chk("frames_6", {24'h0, frames_sent}, 32'd6);
        chk("scb_empty_a", scb.size(), 32'd0);

        // Reset during DATA of byte 2
        data_in = 16'h1234;
        push_frame(16'h1234);
        wait_busy(1'b1);
        repeat (90) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx", {31'h0, tx}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_frames", {24'h0, frames_sent}, 32'h0);
        repeat (3) @(negedge clk);
        scb.delete();
        push_frame(16'h1234);
        rst = 1'b0;
        wait_busy(1'b1);
        wait_busy(1'b0);
        chk("frames_after_rst", {24'h0, frames_sent}, 32'd1);

        // 255 back-to-back frames wrap frames_sent from 1 to 0
        v = 16'h1000;
        data_in = v;
        push_frame(v);
        wait_busy(1'b1);
        for (int i = 1; i < 255; i++) begin
            v = 16'h1000 + 16'(i);
            data_in = v;
            push_frame(v);
            wait_busy(1'b0);
            gap_en = 1'b1;
            wait_busy(1'b1);
        end
        wait_busy(1'b0);
        gap_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("frames_wrap", {24'h0, frames_sent}, 32'd0);
        chk("scb_empty_b", scb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
